gsau_wb_buffer: RTL

GSAU_WB_BUFFER -- requirements
Module: gsau_wb_buffer

---
 rtl/gsau_wb_buffer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/gsau_wb_buffer.sv
// GSAU writeback buffer.
// Queues psum rows from the GSAU and drains each one to the vector register file
// as PSUM_W/BEAT_W write beats, lowest beat first, strictly in push order.
// A one-cycle completion pulse goes to the scoreboard after each entry's last beat.
//
// Ports:
//   CLK, RST         clock (rising edge), asynchronous active-high reset
//   wb_valid         psum valid from GSAU
//   wb_psum          psum row
//   wb_wbdst         destination vector register
//   wb_output_ready  buffer has room (registered occupancy < DEPTH)
//   veg_wr_en        write beat valid
//   veg_wr_addr      destination register of the current beat
//   veg_wr_beat      beat index within the entry
//   veg_wr_data      beat data
//   veg_wr_ready     register file accepts the beat
//   sb_wb_done       one-cycle completion pulse
//   sb_wb_vdst       register completed by sb_wb_done
//   occupancy        registered entry count
module gsau_wb_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PSUM_W = 512,
    parameter int unsigned BEAT_W = 128,
    parameter int unsigned VDST_W = 8,
    localparam int unsigned NBEATS  = PSUM_W / BEAT_W,
    localparam int unsigned BEAT_IW = (NBEATS > 1) ? $clog2(NBEATS) : 1,
    localparam int unsigned OCC_W   = $clog2(DEPTH) + 1,
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               wb_valid,
    input  logic [PSUM_W-1:0]  wb_psum,
    input  logic [VDST_W-1:0]  wb_wbdst,
    output logic               wb_output_ready,
    output logic               veg_wr_en,
    output logic [VDST_W-1:0]  veg_wr_addr,
    output logic [BEAT_IW-1:0] veg_wr_beat,
    output logic [BEAT_W-1:0]  veg_wr_data,
    input  logic               veg_wr_ready,
    output logic               sb_wb_done,
    output logic [VDST_W-1:0]  sb_wb_vdst,
    output logic [OCC_W-1:0]   occupancy
);

    localparam logic [OCC_W-1:0]   DEPTH_OCC = OCC_W'(DEPTH);
    localparam logic [BEAT_IW-1:0] LAST_BEAT = BEAT_IW'(NBEATS - 1);
    localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(DEPTH - 1);

    typedef enum logic {StIdle, StWrite} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [BEAT_IW-1:0] beat_q;
    logic               done_q;
    logic [VDST_W-1:0]  done_vdst_q;

    logic [PSUM_W-1:0]  psum_mem [DEPTH];
    logic [VDST_W-1:0]  vdst_mem [DEPTH];

    logic push, accept, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends on registered occupancy only, so a pop never frees a slot
    // for a push in the same cycle.
    assign wb_output_ready = (occ_q < DEPTH_OCC);
    assign push            = wb_valid && wb_output_ready;
    assign accept          = veg_wr_en && veg_wr_ready;
    assign pop             = accept && (beat_q == LAST_BEAT);

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // FSM: state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (occ_q != '0) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // occ_d already counts a same-edge push, so back-to-back
                // entries continue without a bubble.
                if (pop && (occ_d == '0)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs; all beat outputs are zero outside WRITE.
    always_comb begin
        veg_wr_en   = 1'b0;
        veg_wr_addr = '0;
        veg_wr_beat = '0;
        veg_wr_data = '0;
        unique case (state_q)
            StIdle: ;
            StWrite: begin
                veg_wr_en   = 1'b1;
                veg_wr_addr = vdst_mem[head_q];
                veg_wr_beat = beat_q;
                veg_wr_data = psum_mem[head_q][beat_q * BEAT_W +: BEAT_W];
            end
            default: ;
        endcase
    end

    // Pointers, occupancy, beat counter and completion pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            beat_q      <= '0;
            done_q      <= 1'b0;
            done_vdst_q <= '0;
        end else begin
            occ_q  <= occ_d;
            done_q <= pop;
            if (push) begin
                tail_q <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q      <= ptr_inc(head_q);
                beat_q      <= '0;
                done_vdst_q <= vdst_mem[head_q];
            end else if (accept) begin
                beat_q <= beat_q + BEAT_IW'(1);
            end
        end
    end

    // Entry storage needs no reset: it is only read while occupancy covers it.
    always_ff @(posedge CLK) begin
        if (push) begin
            psum_mem[tail_q] <= wb_psum;
            vdst_mem[tail_q] <= wb_wbdst;
        end
    end

    assign sb_wb_done = done_q;
    assign sb_wb_vdst = done_vdst_q;
    assign occupancy  = occ_q;

endmodule
